// File: rtl/level0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : level0_pkg
// Description : Shared types and constants for the level-0 stream controller.
//               Holds the controller state encoding, the default geometry of
//               the level-0 register file and the entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package level0_pkg;

  localparam int L0_DATA_W = 48;  // 3 x 16-bit fields
  localparam int L0_ADDR_W = 4;
  localparam int L0_DEPTH  = 10;

  typedef logic [L0_DATA_W-1:0] l0_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOADED = 2'd2,
    ST_READ   = 2'd3
  } l0_state_e;

endpackage : level0_pkg
`default_nettype wire

// File: rtl/l0_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : l0_skid_buf
// Description : 2-entry FIFO that absorbs register-file read data while the
//               downstream consumer applies backpressure.
// Ports       : clk, rst_n     - clock / asynchronous active-low reset
//               flush_i        - synchronous flush (wins over push/pop)
//               push_i, din_i  - write side
//               pop_i          - read side (ignored when empty)
//               occ_o          - number of stored entries (0..2)
//               head_o         - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module l0_skid_buf #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] slot0_q;  // head
  logic [WIDTH-1:0] slot1_q;
  logic [1:0]       occ_q;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop_i && (occ_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push = push_i && ((occ_q != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else if (flush_i) begin
      occ_q <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (occ_q == 2'd0) slot0_q <= din_i;
          else               slot1_q <= din_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            slot0_q <= din_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = slot0_q;

endmodule : l0_skid_buf
`default_nettype wire

// File: rtl/level0_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : level0_stream_ctrl
// Description : Front-end controller for the level-0 register file
//               (1R/1W, 1-cycle read latency). Loads a valid/ready stream of
//               entries at consecutive addresses, then replays them on
//               command as a valid/ready stream with full backpressure.
// Ports       : clk, rst_n, clear         - clock, async reset, sync abort
//               in_valid/in_ready/in_data/in_last      - load stream
//               rd_start                  - replay command (LOADED only)
//               out_valid/out_ready/out_data/out_last - replay stream
//               count, busy               - status
//               mem_cen_n/mem_wen/mem_addr/mem_wdata/mem_rdata - RF port
// Revision    : 1.0 - initial release
// ============================================================================
module level0_stream_ctrl
  import level0_pkg::*;
#(
  parameter int DATA_W = L0_DATA_W,
  parameter int ADDR_W = L0_ADDR_W,
  parameter int DEPTH  = L0_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              rd_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              mem_cen_n,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);

  l0_state_e         state_q;
  logic              in_ready_q;
  logic              busy_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  delivered_q;  // index of the current skid head
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              inflight_q;   // read issued last cycle, data on mem_rdata now

  logic              w_wr;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_head;
  logic [2:0]        w_pending;

  // clear must stop a handshake in the very cycle it is asserted.
  assign in_ready = in_ready_q & ~clear;
  assign w_wr     = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready & ~clear;

  // Entries that will still be held after this cycle. Counting the pop lets a
  // new read issue while the head leaves, which keeps the replay gap-free
  // under continuous out_ready without ever exceeding two held entries.
  assign w_pending = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};

  assign w_issue = (state_q == ST_READ) && !clear &&
                   (CNT_W'(rd_ptr_q) < count_q) && (w_pending < 3'd2);

  l0_skid_buf #(
    .WIDTH (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clear),
    .push_i  (inflight_q),
    .din_i   (mem_rdata),
    .pop_i   (w_pop),
    .occ_o   (w_occ),
    .head_o  (w_head)
  );

  assign out_valid = (w_occ != 2'd0);
  assign out_data  = w_head;
  assign out_last  = out_valid && (delivered_q == (count_q - C_CNT_ONE));
  assign count     = count_q;
  assign busy      = busy_q;

  // Writes and reads are mutually exclusive: in_ready is only high outside READ.
  assign mem_cen_n = ~(w_wr | w_issue);
  assign mem_wen   = w_wr;
  assign mem_addr  = w_wr ? wr_ptr_q : (w_issue ? rd_ptr_q : '0);
  assign mem_wdata = w_wr ? in_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      delivered_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      count_q     <= '0;
      delivered_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= w_issue;
      if (w_issue) rd_ptr_q    <= rd_ptr_q + C_ADDR_ONE;
      if (w_pop)   delivered_q <= delivered_q + C_CNT_ONE;

      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (w_wr) begin
            wr_ptr_q <= wr_ptr_q + C_ADDR_ONE;
            count_q  <= count_q + C_CNT_ONE;
            // In IDLE count_q is 0, so this also covers DEPTH == 1.
            if (in_last || ((count_q + C_CNT_ONE) == C_DEPTH)) begin
              state_q    <= ST_LOADED;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              state_q    <= ST_LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end else begin
            // Covers the first cycle after reset release.
            in_ready_q <= 1'b1;
          end
        end
        ST_LOADED: begin
          if (rd_start && (count_q != '0)) begin
            state_q     <= ST_READ;
            busy_q      <= 1'b1;
            rd_ptr_q    <= '0;
            delivered_q <= '0;
          end
        end
        ST_READ: begin
          if (w_pop && out_last) begin
            state_q <= ST_LOADED;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : level0_stream_ctrl
`default_nettype wire

// File: tb/tb_level0_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_level0_stream_ctrl
// Description : Self-checking bench for level0_stream_ctrl. A behavioural
//               register file answers the memory port; expected contents and
//               replay streams come from a queue-based model of what a load
//               should store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level0_stream_ctrl;

  localparam int DATA_W = 48;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 10;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n, clear, in_valid, in_last, rd_start, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid, out_last, busy, mem_cen_n, mem_wen;
  logic [DATA_W-1:0] out_data, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  level0_stream_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .clear (clear),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_last (in_last),
    .rd_start (rd_start),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_last (out_last),
    .count (count), .busy (busy),
    .mem_cen_n (mem_cen_n), .mem_wen (mem_wen), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  // Behavioural 1R/1W register file with one cycle of read latency.
  logic [DATA_W-1:0] rf [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (!mem_cen_n) begin
      if (mem_wen) rf[mem_addr] <= mem_wdata;
      else         mem_rdata    <= rf[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Observed traffic, sampled mid-cycle after inputs settle.
  logic [ADDR_W-1:0] wr_addr_log [$];
  logic [DATA_W-1:0] wr_data_log [$];
  logic [DATA_W-1:0] out_data_log [$];
  bit                out_last_log [$];
  int n_issued, n_popped, max_out;

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (!mem_cen_n && mem_wen) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_wdata);
      end
      if (!mem_cen_n && !mem_wen) n_issued++;
      if (out_valid && out_ready && !clear) begin
        out_data_log.push_back(out_data);
        out_last_log.push_back(out_last);
        n_popped++;
      end
      if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
    end
  end

  // Reference model: beats offered and entries the block should hold.
  logic [DATA_W-1:0] beats [0:15];
  logic [DATA_W-1:0] model_store [$];
  int n_accepted, first_valid_idx, gaps;
  bit replay_done;

  // A load stores beats up to and including the first in_last, capped at DEPTH.
  function automatic int expected_accepts(input int n, input int last_idx);
    int k = n;
    if (last_idx >= 0 && last_idx + 1 < k) k = last_idx + 1;
    if (k > DEPTH) k = DEPTH;
    return k;
  endfunction

  task automatic reset_logs();
    wr_addr_log.delete(); wr_data_log.delete();
    out_data_log.delete(); out_last_log.delete();
    n_issued = 0; n_popped = 0; max_out = 0;
  endtask

  task automatic make_beats(input int n);
    for (int k = 0; k < n; k++) beats[k] = {16'($urandom), 32'($urandom)};
  endtask

  task automatic set_model(input int n);
    model_store.delete();
    for (int k = 0; k < n; k++) model_store.push_back(beats[k]);
  endtask

  task automatic clear_block();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    model_store.delete();
  endtask

  // Offers beats back to back, advancing only when in_ready is seen.
  task automatic drive_load(input int n, input int last_idx, input int max_cycles);
    int i = 0;
    for (int c = 0; c < max_cycles && i < n; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = beats[i]; in_last = (i == last_idx);
      #1;
      if (in_ready) i++;
    end
    n_accepted = i;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  // pattern 0: out_ready always 1; 1: toggling 1010..; other: random.
  task automatic drive_replay(input int pattern, input int max_cycles);
    first_valid_idx = -1; gaps = 0; replay_done = 1'b0;
    for (int c = 0; c < max_cycles && !replay_done; c++) begin
      @(negedge clk);
      rd_start = (c == 0);
      case (pattern)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (out_valid && first_valid_idx < 0) first_valid_idx = c;
      if (!out_valid && first_valid_idx >= 0) gaps++;
      if (out_valid && out_ready && out_last) replay_done = 1'b1;
    end
    @(negedge clk);
    rd_start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({in_ready, out_valid, out_last, busy, mem_wen} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {in_ready, out_valid, out_last, busy, mem_wen});
    end
    n_cmp++; if (mem_cen_n !== 1'b1) begin n_fail++; $display("FAIL reset_cen_n: got %b expected 1", mem_cen_n); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if ({out_data, mem_wdata, mem_addr} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0", out_data, mem_wdata, mem_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_load_short();
    reset_logs();
    make_beats(3);
    drive_load(3, 2, 20);
    set_model(3);
    #1;
    n_cmp++; if (n_accepted !== 3) begin n_fail++; $display("FAIL short_accepted: got %0d expected 3", n_accepted); end
    n_cmp++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL short_count: got %0d expected 3", count); end
    n_cmp++; if ({in_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL short_loaded: got in_ready/busy %b expected 00", {in_ready, busy}); end
    n_cmp++; if (wr_addr_log.size() !== 3) begin n_fail++; $display("FAIL short_nwrites: got %0d expected 3", wr_addr_log.size()); end
    for (int k = 0; k < 3 && k < wr_addr_log.size(); k++) begin
      n_cmp++; if (wr_addr_log[k] !== ADDR_W'(k) || wr_data_log[k] !== model_store[k]) begin
        n_fail++; $display("FAIL short_write%0d: got @%0d %h expected @%0d %h", k, wr_addr_log[k], wr_data_log[k], k, model_store[k]);
      end
    end
  endtask

  task automatic test_replay_latency();
    reset_logs();
    drive_replay(0, 40);
    #1;
    n_cmp++; if (replay_done !== 1'b1) begin n_fail++; $display("FAIL lat_done: got %b expected 1 (timeout)", replay_done); end
    n_cmp++; if (first_valid_idx !== 3) begin n_fail++; $display("FAIL lat_first_valid: got cycle %0d expected 3", first_valid_idx); end
    n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL lat_gaps: got %0d expected 0", gaps); end
    n_cmp++; if (out_data_log.size() !== model_store.size()) begin
      n_fail++; $display("FAIL lat_nbeats: got %0d expected %0d", out_data_log.size(), model_store.size());
    end
    for (int k = 0; k < model_store.size() && k < out_data_log.size(); k++) begin
      n_cmp++; if (out_data_log[k] !== model_store[k] || out_last_log[k] !== (k == model_store.size() - 1)) begin
        n_fail++; $display("FAIL lat_beat%0d: got %h last=%b expected %h last=%b", k, out_data_log[k], out_last_log[k], model_store[k], k == model_store.size() - 1);
      end
    end
    n_cmp++; if ({busy, out_valid, count} !== {2'b00, CNT_W'(3)}) begin
      n_fail++; $display("FAIL lat_back_loaded: got busy=%b valid=%b count=%0d expected 0 0 3", busy, out_valid, count);
    end
  endtask

  task automatic test_load_overflow();
    clear_block();
    reset_logs();
    make_beats(12);
    drive_load(12, -1, 30);
    set_model(expected_accepts(12, -1));
    #1;
    n_cmp++; if (n_accepted !== DEPTH) begin n_fail++; $display("FAIL ovf_accepted: got %0d expected %0d", n_accepted, DEPTH); end
    n_cmp++; if (count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", count, DEPTH); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (wr_addr_log.size() !== DEPTH) begin n_fail++; $display("FAIL ovf_nwrites: got %0d expected %0d", wr_addr_log.size(), DEPTH); end
    for (int k = 0; k < DEPTH && k < wr_addr_log.size(); k++) begin
      n_cmp++; if (wr_addr_log[k] !== ADDR_W'(k) || wr_data_log[k] !== model_store[k]) begin
        n_fail++; $display("FAIL ovf_write%0d: got @%0d %h expected @%0d %h", k, wr_addr_log[k], wr_data_log[k], k, model_store[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_logs();
    drive_replay(1, 100);
    n_cmp++; if (replay_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1 (timeout)", replay_done); end
    n_cmp++; if (out_data_log.size() !== DEPTH) begin n_fail++; $display("FAIL bp_nbeats: got %0d expected %0d", out_data_log.size(), DEPTH); end
    for (int k = 0; k < DEPTH && k < out_data_log.size(); k++) begin
      n_cmp++; if (out_data_log[k] !== model_store[k] || out_last_log[k] !== (k == DEPTH - 1)) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h last=%b expected %h last=%b", k, out_data_log[k], out_last_log[k], model_store[k], k == DEPTH - 1);
      end
    end
    n_cmp++; if (max_out > 3) begin n_fail++; $display("FAIL bp_outstanding: got %0d expected <= 3", max_out); end
  endtask

  task automatic test_clear_mid_read();
    int pops = 0;
    int issued_before;
    reset_logs();
    for (int c = 0; c < 60 && pops < 4; c++) begin
      @(negedge clk);
      rd_start = (c == 0); out_ready = 1'b1;
      #1;
      if (out_valid) pops++;
    end
    n_cmp++; if (pops !== 4) begin n_fail++; $display("FAIL clr_pops: got %0d expected 4 (timeout)", pops); end
    @(negedge clk);
    rd_start = 1'b0; out_ready = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_cmp++; if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL clr_state: got valid/busy/in_ready %b expected 001", {out_valid, busy, in_ready});
    end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", count); end
    n_cmp++; if (out_data_log.size() !== 4) begin n_fail++; $display("FAIL clr_nbeats: got %0d expected 4", out_data_log.size()); end
    for (int k = 0; k < 4 && k < out_data_log.size(); k++) begin
      n_cmp++; if (out_data_log[k] !== model_store[k]) begin
        n_fail++; $display("FAIL clr_beat%0d: got %h expected %h", k, out_data_log[k], model_store[k]);
      end
    end
    model_store.delete();
    issued_before = n_issued;
    @(negedge clk); rd_start = 1'b1; out_ready = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if ({out_valid, busy} !== 2'b00 || n_issued !== issued_before) begin
      n_fail++; $display("FAIL clr_rd_ignored: got valid=%b busy=%b reads=%0d expected 0 0 %0d", out_valid, busy, n_issued, issued_before);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    reset_logs();
    make_beats(2);
    drive_load(2, -1, 10);
    #1;
    n_cmp++; if ({busy, count} !== {1'b1, CNT_W'(2)}) begin
      n_fail++; $display("FAIL rml_loading: got busy=%b count=%0d expected 1 2", busy, count);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, busy, out_valid, mem_wen, mem_cen_n} !== 5'b00001 || count !== '0) begin
      n_fail++; $display("FAIL rml_async: got rdy/busy/valid/wen/cen_n=%b count=%0d expected 00001 0", {in_ready, busy, out_valid, mem_wen, mem_cen_n}, count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    reset_logs();
    make_beats(3);
    drive_load(3, 2, 20);
    set_model(3);
    #1;
    n_cmp++; if (count !== CNT_W'(3) || wr_addr_log.size() !== 3) begin
      n_fail++; $display("FAIL rml_reload: got count=%0d writes=%0d expected 3 3", count, wr_addr_log.size());
    end
    for (int k = 0; k < 3 && k < wr_addr_log.size(); k++) begin
      n_cmp++; if (wr_addr_log[k] !== ADDR_W'(k) || wr_data_log[k] !== model_store[k]) begin
        n_fail++; $display("FAIL rml_write%0d: got @%0d %h expected @%0d %h", k, wr_addr_log[k], wr_data_log[k], k, model_store[k]);
      end
    end
  endtask

  task automatic test_random();
    int len, last_idx, exp_n;
    for (int it = 0; it < 4; it++) begin
      clear_block();
      reset_logs();
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(DEPTH, DEPTH + 2); last_idx = -1;
      end else begin
        len = $urandom_range(1, DEPTH + 2); last_idx = $urandom_range(0, len - 1);
      end
      make_beats(len);
      drive_load(len, last_idx, 40);
      exp_n = expected_accepts(len, last_idx);
      set_model(exp_n);
      #1;
      n_cmp++; if (count !== CNT_W'(exp_n) || wr_addr_log.size() !== exp_n) begin
        n_fail++; $display("FAIL rand%0d_load: got count=%0d writes=%0d expected %0d", it, count, wr_addr_log.size(), exp_n);
      end
      for (int r = 0; r < 2; r++) begin
        reset_logs();
        drive_replay(2, 150);
        n_cmp++; if (replay_done !== 1'b1 || out_data_log.size() !== exp_n) begin
          n_fail++; $display("FAIL rand%0d_replay%0d: got done=%b beats=%0d expected 1 %0d", it, r, replay_done, out_data_log.size(), exp_n);
        end
        for (int k = 0; k < exp_n && k < out_data_log.size(); k++) begin
          n_cmp++; if (out_data_log[k] !== model_store[k] || out_last_log[k] !== (k == exp_n - 1)) begin
            n_fail++; $display("FAIL rand%0d_beat%0d: got %h last=%b expected %h last=%b", it, k, out_data_log[k], out_last_log[k], model_store[k], k == exp_n - 1);
          end
        end
        n_cmp++; if (max_out > 3) begin n_fail++; $display("FAIL rand%0d_outstanding: got %0d expected <= 3", it, max_out); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rd_start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_load_short();
    test_replay_latency();
    test_load_overflow();
    test_backpressure();
    test_clear_mid_read();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_level0_stream_ctrl
`default_nettype wire
